// File: rtl/jaa_pkg.sv
// Shared definitions for the bytecode-to-ARM translator: bundle geometry,
// emitter state encoding and ARM opcode prefixes.
package jaa_pkg;

  localparam int unsigned WORD_WIDTH = 32;
  localparam int unsigned MAX_WORDS  = 6;
  localparam int unsigned BUNDLE_W   = WORD_WIDTH * MAX_WORDS;
  localparam int unsigned QTY_W      = 4;
  localparam int unsigned PUSH_W     = $clog2(MAX_WORDS + 1);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FULL
  } emit_state_e;

  // Upper instruction bits shared by translator templates
  localparam logic [15:0] ARM_PUSH_PREFIX = 16'hE92D;
  localparam logic [15:0] ARM_POP_PREFIX  = 16'hE8BD;
  localparam logic [11:0] ARM_MOV_PREFIX  = 12'hE3A;
  localparam logic [11:0] ARM_LDR_PREFIX  = 12'hE59;
  localparam logic [11:0] ARM_STR_PREFIX  = 12'hE58;

  function automatic logic [WORD_WIDTH-1:0] arm_push(input logic [15:0] reglist);
    return {ARM_PUSH_PREFIX, reglist};
  endfunction

  function automatic logic [WORD_WIDTH-1:0] arm_pop(input logic [15:0] reglist);
    return {ARM_POP_PREFIX, reglist};
  endfunction

endpackage

// File: rtl/jaa_word_fifo.sv
// Word FIFO: accepts up to MAX_WORDS words per edge from a packed bundle,
// releases one word per edge from the head.
module jaa_word_fifo
  import jaa_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PUSH_W-1:0]     push_n,
  input  logic [BUNDLE_W-1:0]   push_data,
  input  logic                  pop,
  output logic [WORD_WIDTH-1:0] head,
  output logic [CNT_W-1:0]      count
);

  logic [WORD_WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  // Word k of the bundle lands k slots after the current write pointer
  always_ff @(posedge clk) begin
    for (int k = 0; k < int'(MAX_WORDS); k++) begin
      if (PUSH_W'(k) < push_n) begin
        store[wr_ptr + PTR_W'(k)] <= push_data[k*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push_n);
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push_n) - CNT_W'(pop);
    end
  end

  assign head = store[rd_ptr];

endmodule

// File: rtl/arm_code_emitter.sv
// Buffers translated ARM instruction bundles and writes them one word per
// cycle, in order, into a linear code memory that never wraps.
module arm_code_emitter
  import jaa_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [BUNDLE_W-1:0]   instructions,
  input  logic [QTY_W-1:0]      quantity,
  output logic                  ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  output logic [ADDR_WIDTH:0]   words_written,
  output logic                  mem_full,
  output logic                  bad_bundle
);

  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned MEM_WORDS = 1 << ADDR_WIDTH;

  emit_state_e           state;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      free_slots;
  logic [WORD_WIDTH-1:0] head;
  logic [PUSH_W-1:0]     push_n;
  logic                  accept;
  logic                  malformed;
  logic                  pop;
  logic                  last_addr;

  assign free_slots = CNT_W'(FIFO_DEPTH) - count;
  assign ready      = (free_slots >= CNT_W'(MAX_WORDS)) && !mem_full;
  assign accept     = write_enable && ready;
  assign malformed  = quantity > QTY_W'(MAX_WORDS);
  assign push_n     = (accept && !malformed) ? PUSH_W'(quantity) : '0;
  assign pop        = (state != FULL) && !mem_full && (count != '0);
  assign last_addr  = words_written == (ADDR_WIDTH+1)'(MEM_WORDS - 1);

  jaa_word_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_n   (push_n),
    .push_data(instructions),
    .pop      (pop),
    .head     (head),
    .count    (count)
  );

  // FSM, address counter and sticky flags; mem_* outputs are registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      words_written <= '0;
      mem_full      <= 1'b0;
      bad_bundle    <= 1'b0;
    end else begin
      if (accept && malformed) begin
        bad_bundle <= 1'b1;
      end
      case (state)
        FULL: begin
          mem_we <= 1'b0;
        end
        default: begin
          if (mem_full) begin
            state  <= FULL;
            mem_we <= 1'b0;
          end else if (pop) begin
            state         <= DRAIN;
            mem_we        <= 1'b1;
            mem_addr      <= words_written[ADDR_WIDTH-1:0];
            mem_wdata     <= head;
            words_written <= words_written + (ADDR_WIDTH+1)'(1);
            if (last_addr) begin
              mem_full <= 1'b1;
            end
          end else begin
            state  <= IDLE;
            mem_we <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arm_code_emitter.sv
// Randomized bench for arm_code_emitter against a queue-based reference of
// the emitter's accept / in-order write / saturation rules.
module tb_arm_code_emitter;
  import jaa_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  write_enable;
  logic [BUNDLE_W-1:0]   instructions;
  logic [QTY_W-1:0]      quantity;
  logic                  ready;
  logic                  mem_we;
  logic [9:0]            mem_addr;
  logic [WORD_WIDTH-1:0] mem_wdata;
  logic [10:0]           words_written;
  logic                  mem_full;
  logic                  bad_bundle;

  arm_code_emitter dut (
    .clk          (clk),
    .reset        (reset),
    .write_enable (write_enable),
    .instructions (instructions),
    .quantity     (quantity),
    .ready        (ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .words_written(words_written),
    .mem_full     (mem_full),
    .bad_bundle   (bad_bundle)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [WORD_WIDTH-1:0] exp_q[$];
  int exp_addr;
  int exp_written;
  bit exp_full;
  bit exp_bad;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WORD_WIDTH-1:0] rand_word();
    logic [WORD_WIDTH-1:0] w;
    case ($urandom_range(0, 4))
      0: w = arm_push(16'($urandom));
      1: w = arm_pop(16'($urandom));
      2: w = {ARM_MOV_PREFIX, 20'($urandom)};
      3: w = {ARM_LDR_PREFIX, 20'($urandom)};
      default: w = {ARM_STR_PREFIX, 20'($urandom)};
    endcase
    return w;
  endfunction

  function automatic logic [BUNDLE_W-1:0] rand_bundle();
    logic [BUNDLE_W-1:0] b;
    for (int k = 0; k < int'(MAX_WORDS); k++) b[k*WORD_WIDTH +: WORD_WIDTH] = rand_word();
    return b;
  endfunction

  // One clock cycle: drive, predict, advance, compare
  task automatic step(input bit we, input logic [BUNDLE_W-1:0] data, input int qty);
    bit exp_ready;
    bit do_pop;
    logic [WORD_WIDTH-1:0] pw;
    write_enable = we;
    instructions = data;
    quantity     = QTY_W'(qty);
    exp_ready = ((16 - exp_q.size()) >= 6) && !exp_full;
    check("ready", 64'(ready), 64'(exp_ready));
    do_pop = (exp_q.size() > 0) && !exp_full;
    pw = '0;
    if (do_pop) pw = exp_q.pop_front();
    if (we && exp_ready) begin
      if (qty > int'(MAX_WORDS)) exp_bad = 1'b1;
      else for (int k = 0; k < qty; k++) exp_q.push_back(data[k*WORD_WIDTH +: WORD_WIDTH]);
    end
    @(posedge clk);
    #1;
    check("mem_we", 64'(mem_we), 64'(do_pop));
    if (do_pop) begin
      check("mem_addr", 64'(mem_addr), 64'(exp_addr));
      check("mem_wdata", 64'(mem_wdata), 64'(pw));
      exp_addr++;
      exp_written++;
      if (exp_written == 1024) exp_full = 1'b1;
    end else begin
      check("words_written", 64'(words_written), 64'(exp_written));
    end
    check("mem_full", 64'(mem_full), 64'(exp_full));
    check("bad_bundle", 64'(bad_bundle), 64'(exp_bad));
  endtask

  // Asynchronous reset between clock edges, then release and check reset state
  task automatic do_reset();
    #2 reset = 1'b1;
    #1 check("we_async_clear", 64'(mem_we), 64'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    write_enable = 1'b0;
    quantity = '0;
    exp_q.delete();
    exp_addr = 0;
    exp_written = 0;
    exp_full = 1'b0;
    exp_bad = 1'b0;
    check("rst_mem_we", 64'(mem_we), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    check("rst_words", 64'(words_written), 64'(0));
    check("rst_full", 64'(mem_full), 64'(0));
    check("rst_bad", 64'(bad_bundle), 64'(0));
    check("rst_ready", 64'(ready), 64'(1));
  endtask

  initial begin
    logic [BUNDLE_W-1:0] b;
    int cyc;
    reset = 1'b0;
    write_enable = 1'b0;
    instructions = '0;
    quantity = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Two-word bundle, word 0 first
    b = '0;
    b[31:0]  = 32'hE3A01001;
    b[63:32] = 32'hE92D0002;
    step(1'b1, b, 2);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 0);
    check("t1_words", 64'(words_written), 64'(2));

    // Back-to-back full bundles with random write_enable, then drain
    for (int i = 0; i < 40; i++) step(1'b1, rand_bundle(), 6);
    for (int i = 0; i < 60; i++) step(($urandom_range(0, 3) != 0), rand_bundle(), $urandom_range(0, 6));
    for (int i = 0; i < 20; i++) step(1'b0, '0, 0);

    // Empty bundle, malformed bundle, then a normal single word
    step(1'b1, rand_bundle(), 0);
    step(1'b1, rand_bundle(), 7);
    step(1'b1, rand_bundle(), 1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 0);

    // Reset with five words still queued
    do_reset();
    step(1'b1, rand_bundle(), 6);
    step(1'b0, '0, 0);
    check("t5_mid_drain", 64'(mem_we), 64'(1));
    do_reset();
    step(1'b1, rand_bundle(), 1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 0);
    check("t5_restart", 64'(words_written), 64'(1));

    // Malformed bundle offered while not ready is dropped without a flag
    do_reset();
    step(1'b1, rand_bundle(), 6);
    step(1'b1, rand_bundle(), 6);
    check("t6_not_ready", 64'(ready), 64'(0));
    step(1'b1, rand_bundle(), 7);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 0);
    check("t6_no_flag", 64'(bad_bundle), 64'(0));

    // Fill the whole code memory
    do_reset();
    cyc = 0;
    while (!exp_full && cyc < 3000) begin
      step(1'b1, rand_bundle(), $urandom_range(1, 6));
      cyc++;
    end
    if (!exp_full) check("fill_timeout", 64'(0), 64'(1));
    for (int i = 0; i < 10; i++) step(1'b1, rand_bundle(), 6);
    check("t4_words", 64'(words_written), 64'(1024));
    check("t4_full", 64'(mem_full), 64'(1));
    check("t4_ready", 64'(ready), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
